// File: rtl/fpu_issue_queue.sv
// Request FIFO in front of the single-precision FPU stage: accepts {opcode, operands, tag},
// drops and counts unsupported opcodes, and presents the head entry first-word-fall-through.
module fpu_issue_queue #(
  parameter int         DEPTH  = 4,
  parameter int         TAG_W  = 4,
  parameter logic [6:0] OP_ADD = 7'b0000001,
  parameter logic [6:0] OP_SUB = 7'b0000010,
  parameter logic [6:0] OP_MUL = 7'b0000011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [31:0]              in_data1,
  input  logic [31:0]              in_data2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_opcode,
  output logic [31:0]              out_data1,
  output logic [31:0]              out_data2,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [6:0]       r_op   [DEPTH];
  logic [31:0]      r_d1   [DEPTH];
  logic [31:0]      r_d2   [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_drop_count;

  logic w_legal;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // in_ready depends only on stored occupancy, so a pop cannot open a slot in the same cycle.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);

  assign w_legal  = (in_opcode == OP_ADD) || (in_opcode == OP_SUB) || (in_opcode == OP_MUL);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal && !flush;
  assign w_drop   = w_accept && !w_legal;
  assign w_pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_count <= '0;
    end else begin
      // Drops still count during a flush; only queued entries are discarded.
      if (w_drop && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (!w_push && w_pop)
          r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op[r_wr_ptr]  <= in_opcode;
      r_d1[r_wr_ptr]  <= in_data1;
      r_d2[r_wr_ptr]  <= in_data2;
      r_tag[r_wr_ptr] <= in_tag;
    end
  end

  assign out_opcode = out_valid ? r_op[r_rd_ptr]  : '0;
  assign out_data1  = out_valid ? r_d1[r_rd_ptr]  : '0;
  assign out_data2  = out_valid ? r_d2[r_rd_ptr]  : '0;
  assign out_tag    = out_valid ? r_tag[r_rd_ptr] : '0;
  assign count      = r_count;
  assign drop_count = r_drop_count;

endmodule
